// File: rtl/sitcp_tx_mux.sv
// sitcp_tx_mux: per-channel word FIFOs, round-robin arbiter and MSB-first byte serialiser
// feeding the SiTCP TCP_TX_WR/TCP_TX_DATA user interface.
module sitcp_tx_mux #(
  parameter int NCH = 4,
  parameter int WORD_W = 32,
  parameter int DEPTH = 16,
  parameter bit HDR_EN = 1
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    SITCP_RST,
  input  logic                    TCP_OPEN_ACK,
  input  logic                    TCP_TX_FULL,
  input  logic [NCH-1:0]          ch_valid,
  input  logic [NCH*WORD_W-1:0]   ch_data,
  output logic [NCH-1:0]          ch_ready,
  output logic [NCH-1:0]          ch_ovf,
  output logic                    TCP_TX_WR,
  output logic [7:0]              TCP_TX_DATA,
  output logic                    busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WORD_W / 8;
  localparam int BW = $clog2(NB) + 1;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state, state_n;
  logic [WORD_W-1:0] mem [NCH][DEPTH];
  logic [AW:0] wr_ptr [NCH];
  logic [AW:0] rd_ptr [NCH];
  logic [AW:0] cnt_n [NCH];
  logic [NCH-1:0] wr, pop, ne;
  logic [WORD_W-1:0] sh, sh_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [CW-1:0] last, last_n, sel, idx;
  logic found, wr_n;
  logic [7:0] data_n;
  assign busy = state != IDLE;
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr[i] = ch_valid[i] & ch_ready[i];
      ne[i] = wr_ptr[i] != rd_ptr[i];
    end
  end
  // first non-empty channel after the last grant, wrapping around
  always_comb begin
    sel = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CW'((int'(last) + k) % NCH);
      if (!found && ne[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    sh_n = sh;
    bcnt_n = bcnt;
    last_n = last;
    wr_n = 1'b0;
    data_n = TCP_TX_DATA;
    pop = '0;
    case (state)
      IDLE: if (TCP_OPEN_ACK && found) begin
        pop[sel] = 1'b1;
        sh_n = mem[sel][rd_ptr[sel][AW-1:0]];
        last_n = sel;
        bcnt_n = '0;
        state_n = HDR_EN ? HDR : DATA;
      end
      HDR: if (!TCP_OPEN_ACK) state_n = IDLE;
        else if (!TCP_TX_FULL) begin
          wr_n = 1'b1;
          data_n = {4'hA, 4'(last)};
          state_n = DATA;
        end
      DATA: if (!TCP_OPEN_ACK) state_n = IDLE;
        else if (!TCP_TX_FULL) begin
          wr_n = 1'b1;
          data_n = sh[WORD_W-1 -: 8];
          sh_n = sh << 8;
          bcnt_n = bcnt + 1'b1;
          state_n = bcnt == BW'(NB - 1) ? IDLE : DATA;
        end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    for (int i = 0; i < NCH; i++)
      cnt_n[i] = wr_ptr[i] + (AW+1)'(wr[i]) - rd_ptr[i] - (AW+1)'(pop[i]);
  end
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCH; i++)
      if (wr[i]) mem[i][wr_ptr[i][AW-1:0]] <= ch_data[i*WORD_W +: WORD_W];
  end
  // SITCP_RST folds into every next value so it overrides writes, pops and overflow flags
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      sh <= '0;
      bcnt <= '0;
      last <= '0;
      TCP_TX_WR <= 1'b0;
      TCP_TX_DATA <= '0;
      ch_ready <= '1;
      ch_ovf <= '0;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      state <= SITCP_RST ? IDLE : state_n;
      sh <= SITCP_RST ? '0 : sh_n;
      bcnt <= SITCP_RST ? '0 : bcnt_n;
      last <= SITCP_RST ? '0 : last_n;
      TCP_TX_WR <= wr_n & !SITCP_RST;
      TCP_TX_DATA <= SITCP_RST ? '0 : data_n;
      for (int i = 0; i < NCH; i++) begin
        wr_ptr[i] <= SITCP_RST ? '0 : wr_ptr[i] + (AW+1)'(wr[i]);
        rd_ptr[i] <= SITCP_RST ? '0 : rd_ptr[i] + (AW+1)'(pop[i]);
        ch_ready[i] <= SITCP_RST | (cnt_n[i] < (AW+1)'(DEPTH));
        ch_ovf[i] <= !SITCP_RST & (ch_ovf[i] | (ch_valid[i] & !ch_ready[i]));
      end
    end
  end
endmodule

// File: tb/tb_sitcp_tx_mux.sv
// tb_sitcp_tx_mux: single-word vector table, directed back-pressure/overflow/abort/flush
// sequences, and randomized fill-then-drain rounds checked against a queue-based model.
module tb_sitcp_tx_mux;
  localparam int NCH = 4, WW = 32, DEPTH = 16;
  typedef struct {int ch; logic [31:0] w; logic [7:0] hdr;} vec_t;
  logic CLK = 0, RSTn = 1, SITCP_RST = 0, TCP_OPEN_ACK = 0, TCP_TX_FULL = 0;
  logic [NCH-1:0] ch_valid = '0;
  logic [NCH*WW-1:0] ch_data = '0;
  logic [NCH-1:0] ch_ready, ch_ovf;
  logic TCP_TX_WR, busy;
  logic [7:0] TCP_TX_DATA;
  int n_chk = 0, n_pass = 0, cyc = 0, viol = 0, base = 0, c0 = 0, mlast = 0;
  logic fe = 0;
  logic [7:0] got [$];
  int got_cyc [$];
  logic [31:0] mq [NCH][$];
  logic [NCH-1:0] movf = '0;
  logic [7:0] exp_q [$];
  logic [7:0] ho [6];
  vec_t tbl [4];

  sitcp_tx_mux #(.NCH(NCH), .WORD_W(WW), .DEPTH(DEPTH), .HDR_EN(1)) dut (
    .CLK(CLK), .RSTn(RSTn), .SITCP_RST(SITCP_RST), .TCP_OPEN_ACK(TCP_OPEN_ACK),
    .TCP_TX_FULL(TCP_TX_FULL), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .ch_ovf(ch_ovf), .TCP_TX_WR(TCP_TX_WR), .TCP_TX_DATA(TCP_TX_DATA), .busy(busy));

  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    fe <= TCP_TX_FULL;
  end
  always @(negedge CLK) if (TCP_TX_WR) begin
    got.push_back(TCP_TX_DATA);
    got_cyc.push_back(cyc);
    if (fe) viol++;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    movf = '0;
    mlast = 0;
  endtask

  task automatic flush();
    SITCP_RST = 1;
    tick();
    SITCP_RST = 0;
    model_clear();
  endtask

  // drive one channel for the next edge; the model accepts only while the FIFO has room
  task automatic put(int c, logic [31:0] w);
    ch_data[c*WW +: WW] = w;
    ch_valid[c] = 1'b1;
    if (mq[c].size() < DEPTH) mq[c].push_back(w);
    else movf[c] = 1'b1;
  endtask

  function automatic logic [NCH-1:0] model_ready();
    for (int c = 0; c < NCH; c++) model_ready[c] = mq[c].size() < DEPTH;
  endfunction

  task automatic model_drain();
    bit any = 1;
    exp_q.delete();
    while (any) begin
      any = 0;
      for (int k = 1; k <= NCH && !any; k++) begin
        int c = (mlast + k) % NCH;
        if (mq[c].size() > 0) begin
          logic [31:0] w = mq[c].pop_front();
          exp_q.push_back(8'hA0 | 8'(c));
          for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
          mlast = c;
          any = 1;
        end
      end
    end
  endtask

  task automatic drain_check(string nm, bit rnd_full);
    int b0 = got.size();
    int t = 0;
    model_drain();
    TCP_OPEN_ACK = 1;
    while (got.size() < b0 + exp_q.size() && t < 4000) begin
      TCP_TX_FULL = rnd_full ? ($urandom_range(0, 2) == 0) : 1'b0;
      tick();
      t++;
    end
    TCP_TX_FULL = 0;
    tick(8);
    chk({nm, "_len"}, 64'(got.size() - b0), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && b0 + i < got.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), got[b0+i], exp_q[i]);
  endtask

  initial begin
    tbl[0] = '{1, 32'h11223344, 8'hA1};
    tbl[1] = '{0, 32'hDEADBEEF, 8'hA0};
    tbl[2] = '{3, 32'h0055AA01, 8'hA3};
    tbl[3] = '{2, 32'hFFFFFFFF, 8'hA2};
    ho = '{8'hA2, 8'hA3, 8'hA0, 8'hA2, 8'hA3, 8'hA0};
    #1 RSTn = 0;
    #2;
    chk("rst_ready", ch_ready, 4'hF);
    chk("rst_ovf", ch_ovf, 0);
    chk("rst_wr", TCP_TX_WR, 0);
    chk("rst_data", TCP_TX_DATA, 0);
    chk("rst_busy", busy, 0);
    tick(2);
    RSTn = 1;
    tick(2);
    // single word: header two edges after acceptance, then four consecutive data bytes
    foreach (tbl[v]) begin
      flush();
      base = got.size();
      TCP_OPEN_ACK = 1;
      put(tbl[v].ch, tbl[v].w);
      tick();
      c0 = cyc;
      ch_valid = '0;
      tick(9);
      chk($sformatf("vec%0d_len", v), 64'(got.size() - base), 5);
      if (got.size() >= base + 5) begin
        chk($sformatf("vec%0d_hdr", v), got[base], tbl[v].hdr);
        chk($sformatf("vec%0d_word", v), {got[base+1], got[base+2], got[base+3], got[base+4]}, tbl[v].w);
        chk($sformatf("vec%0d_hdr_lat", v), 64'(got_cyc[base] - c0), 2);
        chk($sformatf("vec%0d_span", v), 64'(got_cyc[base+4] - got_cyc[base]), 4);
      end
      chk($sformatf("vec%0d_busy", v), busy, 0);
    end
    // round-robin over channels 0, 2, 3 starting after last grant 0
    flush();
    TCP_OPEN_ACK = 0;
    for (int r = 0; r < 2; r++) begin
      put(0, 32'h0A000000 + r);
      put(2, 32'h2B000000 + r);
      put(3, 32'h3C000000 + r);
      tick();
      ch_valid = '0;
    end
    base = got.size();
    drain_check("rr", 0);
    for (int j = 0; j < 6; j++)
      if (got.size() >= base + j*5 + 1) chk($sformatf("rr_hdr%0d", j), got[base+j*5], ho[j]);
    // three cycles of back-pressure after the second data byte
    flush();
    TCP_OPEN_ACK = 1;
    base = got.size();
    put(1, 32'h11223344);
    tick();
    ch_valid = '0;
    tick(4);
    TCP_TX_FULL = 1;
    tick(3);
    TCP_TX_FULL = 0;
    tick(6);
    chk("bp_len", 64'(got.size() - base), 5);
    if (got.size() >= base + 5) begin
      chk("bp_stream", {got[base], got[base+1], got[base+2], got[base+3], got[base+4]}, 40'hA111223344);
      chk("bp_gap", 64'(got_cyc[base+3] - got_cyc[base+2]), 4);
    end
    // overflow of channel 0 while disconnected, then drain
    flush();
    TCP_OPEN_ACK = 0;
    base = got.size();
    for (int i = 1; i <= 17; i++) begin
      put(0, 32'hC0DE0000 + i);
      tick();
      ch_valid = '0;
      if (i == 15) chk("ovf_ready15", ch_ready[0], 1);
      if (i == 16) begin
        chk("ovf_ready16", ch_ready[0], 0);
        chk("ovf_not_yet", ch_ovf[0], 0);
      end
    end
    chk("ovf_set", ch_ovf, movf);
    chk("ovf_no_tx", 64'(got.size() - base), 0);
    drain_check("ovf_drain", 1);
    chk("ovf_ready_back", ch_ready, 4'hF);
    chk("ovf_sticky", ch_ovf[0], 1);
    // connection drop after header and one data byte
    flush();
    TCP_OPEN_ACK = 0;
    put(2, 32'h5A5A0001);
    tick();
    put(2, 32'h77665544);
    tick();
    ch_valid = '0;
    base = got.size();
    TCP_OPEN_ACK = 1;
    tick(3);
    TCP_OPEN_ACK = 0;
    tick();
    chk("abort_wr", TCP_TX_WR, 0);
    chk("abort_busy", busy, 0);
    tick(3);
    chk("abort_len", 64'(got.size() - base), 2);
    if (got.size() >= base + 2) chk("abort_bytes", {got[base], got[base+1]}, 16'hA25A);
    void'(mq[2].pop_front());
    mlast = 2;
    drain_check("abort_rest", 0);
    // synchronous flush mid-word, with a simultaneous write attempt
    flush();
    TCP_OPEN_ACK = 0;
    for (int i = 0; i < 17; i++) begin
      for (int c = 0; c < NCH; c++) put(c, 32'h80000000 | $urandom);
      tick();
      ch_valid = '0;
    end
    chk("fl_pre_ovf", ch_ovf, 4'hF);
    TCP_OPEN_ACK = 1;
    tick(4);
    SITCP_RST = 1;
    put(1, 32'h12345678);
    tick();
    SITCP_RST = 0;
    ch_valid = '0;
    model_clear();
    chk("fl_ready", ch_ready, 4'hF);
    chk("fl_ovf", ch_ovf, 0);
    chk("fl_busy", busy, 0);
    chk("fl_wr", TCP_TX_WR, 0);
    chk("fl_data", TCP_TX_DATA, 0);
    base = got.size();
    tick(12);
    chk("fl_quiet", 64'(got.size() - base), 0);
    // asynchronous reset mid-word
    TCP_OPEN_ACK = 0;
    for (int i = 0; i < 17; i++) begin
      put(3, 32'h80000000 | $urandom);
      tick();
      ch_valid = '0;
    end
    TCP_OPEN_ACK = 1;
    tick(3);
    #2 RSTn = 0;
    #1;
    model_clear();
    chk("ar_ready", ch_ready, 4'hF);
    chk("ar_ovf", ch_ovf, 0);
    chk("ar_busy", busy, 0);
    chk("ar_wr", TCP_TX_WR, 0);
    chk("ar_data", TCP_TX_DATA, 0);
    base = got.size();
    tick();
    RSTn = 1;
    tick(12);
    chk("ar_quiet", 64'(got.size() - base), 0);
    // randomized fill while disconnected, then drain under random back-pressure
    for (int r = 0; r < 12; r++) begin
      flush();
      TCP_OPEN_ACK = 0;
      for (int t = 0; t < 40; t++) begin
        for (int c = 0; c < NCH; c++) if ($urandom_range(0, 2) == 0) put(c, $urandom);
        tick();
        ch_valid = '0;
        chk("rnd_ready", ch_ready, model_ready());
        chk("rnd_ovf", ch_ovf, movf);
      end
      drain_check($sformatf("rnd%0d", r), 1);
    end
    chk("full_respected", 64'(viol), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
